// File: rtl/fir_sys_pkg.sv
// Shared types and memory-map constants for the picorv32 FIR subsystem.
package fir_sys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } resp_state_e;

    localparam int unsigned MEM_DEPTH_WORDS  = 32768;
    localparam logic [31:0] MEM_BASE_ADDR    = 32'h0000_0000;
    localparam logic [31:0] STACKADDR        = 32'h0001_86A0;
    localparam logic [31:0] PROGADDR_RESET   = 32'h0000_0000;
    localparam logic [31:0] OOR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Counter increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Single-port word SRAM with per-byte write enables and a registered read port.
module sram_bytewise #(
    parameter int unsigned DEPTH     = 32768,
    parameter int unsigned AW        = 15,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_sram_responder.sv
// CPU memory-bus responder: SRAM with programmable wait states, OOR flagging
// and saturating read/write completion counters.
module wb_sram_responder
    import fir_sys_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] OOR_DATA    = OOR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cyc,
    input  logic [29:0] adr,
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    input  logic        we,
    output logic [31:0] rdt,
    output logic        ack,
    output logic        err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W     = 4;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    resp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [31:0]      rdt_q, rdt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      rd_cnt_q, rd_cnt_d;
    logic [31:0]      wr_cnt_q, wr_cnt_d;

    logic [29:0]      sram_adr_c;
    logic [AW-1:0]    sram_addr_c;
    logic [3:0]       be_c;
    logic [3:0]       sram_be_c;
    logic [31:0]      sram_rdata;
    logic             in_range_c;

    // Read address follows the bus while idle so the registered read is ready by ack.
    assign sram_adr_c  = (state_q == IDLE) ? adr : adr_q;
    assign sram_addr_c = AW'(sram_adr_c - BASE_WORD);
    assign in_range_c  = (adr_q - BASE_WORD) < 30'(DEPTH_WORDS);
    assign sram_be_c   = be_c & {4{resetn}};

    sram_bytewise #(
        .DEPTH     (DEPTH_WORDS),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .addr  (sram_addr_c),
        .wdata (dat_q),
        .be    (sram_be_c),
        .rdata (sram_rdata)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        rdt_d    = rdt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        be_c     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (cyc) begin
                    adr_d   = adr;
                    dat_d   = dat;
                    sel_d   = sel;
                    we_d    = we;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    err_d   = !in_range_c;
                    if (we_q) begin
                        if (in_range_c) be_c = sel_q;
                        wr_cnt_d = sat_inc32(wr_cnt_q);
                    end else begin
                        rdt_d    = in_range_c ? sram_rdata : OOR_DATA;
                        rd_cnt_d = sat_inc32(rd_cnt_q);
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            rdt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            rdt_q    <= rdt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rdt      = rdt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed scoreboard bench for wb_sram_responder: main instance at one wait
// state plus three instances sharing a bus for the wait-state sweep and reset.
module tb_wb_sram_responder;
    import fir_sys_pkg::*;

    localparam int unsigned DEPTH = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, cyc, we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt, rd_count, wr_count;
    logic        ack, err;

    logic        s_resetn, s_cyc, s_we;
    logic [29:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;
    logic [31:0] s0_rdt, s0_rdc, s0_wrc, s3_rdt, s3_rdc, s3_wrc, s15_rdt, s15_rdc, s15_wrc;
    logic        s0_ack, s0_err, s3_ack, s3_err, s15_ack, s15_err;

    wb_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(MEM_BASE_ADDR), .WAIT_STATES(1),
                        .INIT_FILE(""), .OOR_DATA(OOR_DATA_DEFAULT)) dut (
        .clk(clk), .resetn(resetn), .cyc(cyc), .adr(adr), .dat(dat), .sel(sel), .we(we),
        .rdt(rdt), .ack(ack), .err(err), .rd_count(rd_count), .wr_count(wr_count));

    wb_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(MEM_BASE_ADDR), .WAIT_STATES(0),
                        .INIT_FILE(""), .OOR_DATA(OOR_DATA_DEFAULT)) u_ws0 (
        .clk(clk), .resetn(s_resetn), .cyc(s_cyc), .adr(s_adr), .dat(s_dat), .sel(s_sel), .we(s_we),
        .rdt(s0_rdt), .ack(s0_ack), .err(s0_err), .rd_count(s0_rdc), .wr_count(s0_wrc));

    wb_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(MEM_BASE_ADDR), .WAIT_STATES(3),
                        .INIT_FILE(""), .OOR_DATA(OOR_DATA_DEFAULT)) u_ws3 (
        .clk(clk), .resetn(s_resetn), .cyc(s_cyc), .adr(s_adr), .dat(s_dat), .sel(s_sel), .we(s_we),
        .rdt(s3_rdt), .ack(s3_ack), .err(s3_err), .rd_count(s3_rdc), .wr_count(s3_wrc));

    wb_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(MEM_BASE_ADDR), .WAIT_STATES(15),
                        .INIT_FILE(""), .OOR_DATA(OOR_DATA_DEFAULT)) u_ws15 (
        .clk(clk), .resetn(s_resetn), .cyc(s_cyc), .adr(s_adr), .dat(s_dat), .sel(s_sel), .we(s_we),
        .rdt(s15_rdt), .ack(s15_ack), .err(s15_err), .rd_count(s15_rdc), .wr_count(s15_wrc));

    typedef struct {
        logic [31:0] rdt;
        logic        err;
        logic [31:0] rdc;
        logic [31:0] wrc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [int];
    logic [31:0] m_rdt = 32'h0;
    logic [31:0] m_rdc = 32'h0;
    logic [31:0] m_wrc = 32'h0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : v + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction on the main instance; expectation queued before driving.
    task automatic txn(input logic w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
        exp_t        e;
        logic        inr;
        logic [31:0] cur;
        int          n;
        bit          got;
        inr = (a < 30'(DEPTH));
        if (w) begin
            if (inr) begin
                cur = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 32'h0;
                for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
                mdl_mem[int'(a)] = cur;
            end
            m_wrc = sat(m_wrc);
        end else begin
            m_rdt = inr ? mdl_mem[int'(a)] : OOR_DATA_DEFAULT;
            m_rdc = sat(m_rdc);
        end
        e.rdt = m_rdt; e.err = !inr; e.rdc = m_rdc; e.wrc = m_wrc;
        sb.push_back(e);

        @(posedge clk); #1;
        cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); n++; #1;
            if (n == 1) begin
                adr = ~a; dat = ~d; sel = ~s; we = ~w;
            end
            if (ack) got = 1;
        end
        cyc = 1'b0;
        check({tag, " latency"}, 32'(n - 1), 32'd2);
        e = sb.pop_front();
        check({tag, " rdt"}, rdt, e.rdt);
        check({tag, " err"}, 32'(err), 32'(e.err));
        check({tag, " rd_count"}, rd_count, e.rdc);
        check({tag, " wr_count"}, wr_count, e.wrc);
        @(posedge clk); #1;
        check({tag, " ack single"}, 32'(ack), 32'd0);
    endtask

    // Single-cycle request on the shared sweep bus, then let all instances drain.
    task automatic s_pulse(input logic w, input logic [29:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        s_cyc = 1'b1; s_we = w; s_adr = a; s_dat = d; s_sel = 4'hF;
        @(posedge clk); #1;
        s_cyc = 1'b0;
        repeat (25) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          first [3];
        int          wsv   [3];
        logic [2:0]  sa;
        logic [29:0] stack_word;
        int          n;
        bit          got;

        first = '{0, 0, 0};
        wsv   = '{0, 3, 15};
        stack_word = 30'((STACKADDR - PROGADDR_RESET) >> 2) - 30'd1;

        resetn = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        s_resetn = 1'b0; s_cyc = 1'b0; s_we = 1'b0; s_adr = '0; s_dat = '0; s_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdt", rdt, 32'h0);
        check("reset ack", 32'(ack), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset rd_count", rd_count, 32'h0);
        check("reset wr_count", wr_count, 32'h0);
        resetn = 1'b1; s_resetn = 1'b1;

        txn(1'b1, 30'd0, 32'hCAFE_0000, 4'hF, "preload mem0");
        txn(1'b1, 30'd4, 32'h1234_5678, 4'hF, "preload mem4");
        txn(1'b0, 30'd4, 32'h0, 4'h0, "read mem4");
        txn(1'b1, 30'd8, 32'hAAAA_AAAA, 4'hF, "preload mem8");
        txn(1'b1, 30'd8, 32'h1122_3344, 4'b0101, "lane write mem8");
        txn(1'b0, 30'd8, 32'h0, 4'h0, "read mem8 lanes");
        txn(1'b1, 30'd8, 32'h0000_0000, 4'b0000, "sel0 write mem8");
        txn(1'b0, 30'd8, 32'h0, 4'h0, "read mem8 after sel0");
        txn(1'b0, 30'(DEPTH), 32'h0, 4'h0, "oor read");
        txn(1'b1, 30'(DEPTH), 32'h0000_0000, 4'hF, "oor write");
        txn(1'b0, 30'd0, 32'h0, 4'h0, "read mem0 after oor");
        txn(1'b0, 30'h3FFF_FFFF, 32'h0, 4'h0, "oor read top");
        txn(1'b1, stack_word, 32'h5555_AAAA, 4'hF, "write stack top");
        txn(1'b0, stack_word, 32'h0, 4'h0, "read stack top");

        // Saturation: preset the read counter just below all-ones.
        @(posedge clk); #1;
        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.rd_cnt_q;
        m_rdc = 32'hFFFF_FFFE;
        check("sat preset", rd_count, 32'hFFFF_FFFE);
        txn(1'b0, 30'd4, 32'h0, 4'h0, "sat read1");
        txn(1'b0, 30'd4, 32'h0, 4'h0, "sat read2");
        txn(1'b0, 30'd4, 32'h0, 4'h0, "sat read3");

        // Wait-state sweep with cyc held through the ack cycle.
        @(posedge clk); #1;
        s_cyc = 1'b1; s_we = 1'b0; s_adr = 30'd0; s_sel = 4'hF;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            sa = {s15_ack, s3_ack, s0_ack};
            for (int j = 0; j < 3; j++) begin
                if (first[j] == 0) begin
                    if (sa[j]) first[j] = k;
                end else if (k == first[j] + 1) begin
                    check($sformatf("ws%0d no second ack", wsv[j]), 32'(sa[j]), 32'd0);
                end
            end
        end
        s_cyc = 1'b0;
        for (int j = 0; j < 3; j++)
            check($sformatf("ws%0d latency", wsv[j]), 32'(first[j] - 1), 32'(wsv[j] + 1));
        repeat (40) @(posedge clk);

        // Reset in the middle of a WAIT_STATES=3 write.
        s_pulse(1'b1, 30'd2, 32'h5A5A_5A5A);
        @(posedge clk); #1;
        s_cyc = 1'b1; s_we = 1'b1; s_adr = 30'd2; s_dat = 32'hFFFF_FFFF; s_sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_resetn = 1'b0; s_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("reset hold ack %0d", k), 32'(s3_ack), 32'd0);
        end
        check("busy reset rdt", s3_rdt, 32'h0);
        check("busy reset err", 32'(s3_err), 32'h0);
        check("busy reset rd_count", s3_rdc, 32'h0);
        check("busy reset wr_count", s3_wrc, 32'h0);
        s_resetn = 1'b1;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); n++; #1;
            if (s3_ack) got = 1;
        end
        s_cyc = 1'b0;
        check("post reset accept latency", 32'(n - 1), 32'd4);
        check("post reset mem2 unchanged", s3_rdt, 32'h5A5A_5A5A);
        check("post reset rd_count", s3_rdc, 32'd1);
        check("post reset wr_count", s3_wrc, 32'd0);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
